pe_core_v3: RTL and testbench

Parametrised successor to the v2 processing-element core. It executes the same opcode/func instruction set (integer ALU, activation/min-max group, compare) over a configurable data width. Operand input and result output each use a valid/ready handshake, with an output FIFO for backpressure. Divide runs as a multi-cycle iterative operation, and every result carries a tag and an error flag. It sits between the PE dispatch stage and the writeback arbiter.

---
 rtl/pe_core_v3.sv | 227 ++++++++++++++++++++++
 tb/tb_pe_core_v3.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_core_v3.sv
// Processing-element core: ALU, signed activation and compare ops with a result FIFO.
// Define PE_V3_DIV_EN to build in the iterative restoring divider (ALU func 4).
module pe_core_v3 #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_func,
   input  logic [DATA_W-1:0] in_op1,
   input  logic [DATA_W-1:0] in_op2,
   input  logic [DATA_W-1:0] in_op3,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic              busy
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [6:0] OP_ALU = 7'b0000001;
   localparam logic [6:0] OP_ACT = 7'b0000010;
   localparam logic [6:0] OP_CMP = 7'b0010000;

   typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

   state_t state_q, state_d;

   logic signed [DATA_W-1:0] sa, sb, sc;
   logic [SH_W-1:0]          sh_amt;
   logic [DATA_W-1:0]        op_result;
   logic                     op_err;
   logic                     op_div;
   logic                     cmp_flag;
   logic                     accept;

   logic                     div_done;
   logic [DATA_W-1:0]        div_result;
   logic                     div_err;
   logic [TAG_W-1:0]         div_tag;

   logic                     push, pop;
   logic [DATA_W-1:0]        push_result;
   logic [TAG_W-1:0]         push_tag;
   logic                     push_err;

   logic [DATA_W-1:0]        mem_res [FIFO_DEPTH];
   logic [TAG_W-1:0]         mem_tag [FIFO_DEPTH];
   logic                     mem_err [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;

   assign sa     = in_op1;
   assign sb     = in_op2;
   assign sc     = in_op3;
   assign sh_amt = in_op2[SH_W-1:0];

   // Single-cycle decode; illegal pairs leave the result at zero and flag err.
   always_comb begin
      op_result = '0;
      op_err    = 1'b0;
      op_div    = 1'b0;
      cmp_flag  = 1'b0;
      case (in_opcode)
         OP_ALU: begin
            case (in_func)
               5'd1:  op_result = in_op1 + in_op2;
               5'd2:  op_result = in_op1 - in_op2;
               5'd3:  op_result = in_op1 * in_op2;
               5'd4: begin
`ifdef PE_V3_DIV_EN
                  op_div = 1'b1;
`else
                  op_err = 1'b1;
`endif
               end
               5'd5:  op_result = in_op1 * in_op2 + in_op3;
               5'd9:  op_result = in_op1 & in_op2;
               5'd10: op_result = in_op1 | in_op2;
               5'd11: op_result = in_op1 ^ in_op2;
               5'd12: op_result = in_op1 << sh_amt;
               5'd13: op_result = in_op1 >> sh_amt;
               default: op_err = 1'b1;
            endcase
         end
         OP_ACT: begin
            case (in_func)
               5'd1:  op_result = sa * sb + sc;
               5'd11: op_result = in_op1[DATA_W-1] ? '0 : in_op1;
               5'd13: op_result = in_op1[DATA_W-1] ? -in_op1 : in_op1;
               5'd14: op_result = -in_op1;
               5'd16: op_result = (sa < sb) ? in_op1 : in_op2;
               5'd17: op_result = (sa > sb) ? in_op1 : in_op2;
               default: op_err = 1'b1;
            endcase
         end
         OP_CMP: begin
            case (in_func)
               5'd1: cmp_flag = (sa == sb);
               5'd2: cmp_flag = (sa != sb);
               5'd3: cmp_flag = (sa <  sb);
               5'd4: cmp_flag = (sa <= sb);
               5'd5: cmp_flag = (sa >  sb);
               5'd6: cmp_flag = (sa >= sb);
               default: op_err = 1'b1;
            endcase
            op_result = {{(DATA_W-1){1'b0}}, cmp_flag};
         end
         default: op_err = 1'b1;
      endcase
   end

   assign in_ready = (state_q == IDLE) && (count < DEPTH_C);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && op_div) state_d = DIV;
         DIV:     if (div_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef PE_V3_DIV_EN
   localparam logic [SH_W-1:0] DIV_LAST = SH_W'(DATA_W - 1);

   logic [DATA_W-1:0]   div_rem, div_quo, div_den;
   logic [SH_W-1:0]     div_cnt;
   logic                div_zero;
   logic [TAG_W-1:0]    div_tag_q;
   logic [2*DATA_W-1:0] div_next;

   // One restoring step: shift the next dividend bit into the remainder, keep the
   // subtraction only if it does not go negative. A zero divisor yields all-ones.
   function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                    input logic [DATA_W-1:0] quo,
                                                    input logic [DATA_W-1:0] den);
      logic [DATA_W:0] trial;
      trial = {rem, quo[DATA_W-1]} - {1'b0, den};
      if (trial[DATA_W]) div_step = {rem[DATA_W-2:0], quo[DATA_W-1], quo[DATA_W-2:0], 1'b0};
      else               div_step = {trial[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
   endfunction

   assign div_next = div_step(div_rem, div_quo, div_den);

   always_ff @(posedge clk) begin
      if (!rst_n)                 div_cnt <= '0;
      else if (accept && op_div)  div_cnt <= '0;
      else if (state_q == DIV)    div_cnt <= div_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (accept && op_div) begin
         div_rem   <= '0;
         div_quo   <= in_op1;
         div_den   <= in_op2;
         div_tag_q <= in_tag;
         div_zero  <= (in_op2 == '0);
      end else if (state_q == DIV) begin
         {div_rem, div_quo} <= div_next;
      end
   end

   assign div_done   = (state_q == DIV) && (div_cnt == DIV_LAST);
   assign div_result = div_next[DATA_W-1:0];
   assign div_err    = div_zero;
   assign div_tag    = div_tag_q;
`else
   assign div_done   = 1'b0;
   assign div_result = '0;
   assign div_err    = 1'b0;
   assign div_tag    = '0;
`endif

   // Result FIFO; never pushed while full because acceptance requires free space.
   assign push        = (accept && !op_div) || div_done;
   assign pop         = out_valid && out_ready;
   assign push_result = div_done ? div_result : op_result;
   assign push_tag    = div_done ? div_tag    : in_tag;
   assign push_err    = div_done ? div_err    : op_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_res[wr_ptr] <= push_result;
         mem_tag[wr_ptr] <= push_tag;
         mem_err[wr_ptr] <= push_err;
      end
   end

   assign out_valid  = (count != '0);
   assign out_result = out_valid ? mem_res[rd_ptr] : '0;
   assign out_tag    = out_valid ? mem_tag[rd_ptr] : '0;
   assign out_err    = out_valid ? mem_err[rd_ptr] : 1'b0;
   assign busy       = (state_q == DIV) || out_valid;

endmodule

// File: tb/tb_pe_core_v3.sv
// Directed self-checking bench for pe_core_v3 (DATA_W=32, FIFO_DEPTH=4, TAG_W=4).
module tb_pe_core_v3;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;
   localparam logic [6:0] ALU = 7'b0000001;
   localparam logic [6:0] ACT = 7'b0000010;
   localparam logic [6:0] CMP = 7'b0010000;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_opcode;
   logic [4:0]        in_func;
   logic [DATA_W-1:0] in_op1, in_op2, in_op3;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;
   logic              out_err;
   logic              busy;

   int errors = 0;
   int checks = 0;

   pe_core_v3 #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_func(in_func),
      .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_err(out_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] opc, input logic [4:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] tg);
      int w;
      w = 0;
      while (!in_ready && w < 200) begin
         tick();
         w++;
      end
      chk("send_wait", 32'(w < 200), 32'd1);
      in_opcode = opc;
      in_func   = fn;
      in_op1    = a;
      in_op2    = b;
      in_op3    = c;
      in_tag    = tg;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic expect_head(input string name, input logic [31:0] res,
                              input logic [3:0] tg, input logic er);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk(name, out_result, res);
      chk({name, "_tag"}, 32'(out_tag), 32'(tg));
      chk({name, "_err"}, 32'(out_err), 32'(er));
   endtask

   // Issue one single-cycle op with out_ready high, check the head, let it pop.
   task automatic op1(input string name, input logic [6:0] opc, input logic [4:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [3:0] tg, input logic [31:0] res, input logic er);
      send(opc, fn, a, b, c, tg);
      expect_head(name, res, tg, er);
      tick();
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_opcode = '0; in_func = '0; in_op1 = '0; in_op2 = '0; in_op3 = '0; in_tag = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      out_ready = 1'b1;
      op1("add", ALU, 5'd1, 32'd10, 32'd20, 32'd0, 4'd3, 32'd30, 1'b0);
      chk("add_popped", 32'(out_valid), 32'd0);
      op1("sub", ALU, 5'd2, 32'd5, 32'd7, 32'd0, 4'd1, 32'hFFFF_FFFE, 1'b0);
      op1("mul", ALU, 5'd3, 32'd7, 32'd6, 32'd0, 4'd2, 32'd42, 1'b0);
      op1("mad", ALU, 5'd5, 32'd3, 32'd4, 32'd5, 4'd4, 32'd17, 1'b0);
      op1("and", ALU, 5'd9, 32'hF0F0, 32'hFF00, 32'd0, 4'd5, 32'hF000, 1'b0);
      op1("or", ALU, 5'd10, 32'hF0, 32'h0F, 32'd0, 4'd6, 32'hFF, 1'b0);
      op1("xor", ALU, 5'd11, 32'hFF, 32'h0F, 32'd0, 4'd7, 32'hF0, 1'b0);
      op1("shl_mask", ALU, 5'd12, 32'd1, 32'd35, 32'd0, 4'd8, 32'd8, 1'b0);
      op1("shr", ALU, 5'd13, 32'h8000_0000, 32'd31, 32'd0, 4'd9, 32'd1, 1'b0);
      op1("relu_neg", ACT, 5'd11, -32'sd10, 32'd0, 32'd0, 4'd1, 32'd0, 1'b0);
      op1("relu_pos", ACT, 5'd11, 32'd5, 32'd0, 32'd0, 4'd2, 32'd5, 1'b0);
      op1("abs", ACT, 5'd13, -32'sd100, 32'd0, 32'd0, 4'd3, 32'd100, 1'b0);
      op1("abs_min", ACT, 5'd13, 32'h8000_0000, 32'd0, 32'd0, 4'd4, 32'h8000_0000, 1'b0);
      op1("neg", ACT, 5'd14, 32'd50, 32'd0, 32'd0, 4'd5, 32'hFFFF_FFCE, 1'b0);
      op1("min", ACT, 5'd16, 32'd10, 32'd20, 32'd0, 4'd6, 32'd10, 1'b0);
      op1("min_signed", ACT, 5'd16, -32'sd5, 32'd3, 32'd0, 4'd7, 32'hFFFF_FFFB, 1'b0);
      op1("max_signed", ACT, 5'd17, -32'sd5, 32'd3, 32'd0, 4'd8, 32'd3, 1'b0);
      op1("fma", ACT, 5'd1, 32'd2, 32'd3, 32'd10, 4'd9, 32'd16, 1'b0);
      op1("fma_neg", ACT, 5'd1, -32'sd2, 32'd3, 32'd1, 4'd10, 32'hFFFF_FFFB, 1'b0);
      op1("cmp_lt", CMP, 5'd3, -32'sd1, 32'd1, 32'd0, 4'd11, 32'd1, 1'b0);
      op1("cmp_eq", CMP, 5'd1, 32'd5, 32'd5, 32'd0, 4'd12, 32'd1, 1'b0);
      op1("cmp_ne", CMP, 5'd2, 32'd5, 32'd5, 32'd0, 4'd13, 32'd0, 1'b0);
      op1("cmp_le", CMP, 5'd4, 32'd3, 32'd3, 32'd0, 4'd14, 32'd1, 1'b0);
      op1("cmp_gt", CMP, 5'd5, -32'sd1, 32'd1, 32'd0, 4'd15, 32'd0, 1'b0);
      op1("cmp_ge", CMP, 5'd6, 32'd1, -32'sd1, 32'd0, 4'd0, 32'd1, 1'b0);
      op1("ill_opcode", 7'b1111111, 5'd1, 32'd9, 32'd9, 32'd0, 4'd1, 32'd0, 1'b1);
      op1("ill_alu_func", ALU, 5'd6, 32'd9, 32'd9, 32'd0, 4'd2, 32'd0, 1'b1);
      op1("ill_cmp_func", CMP, 5'd7, 32'd9, 32'd9, 32'd0, 4'd3, 32'd0, 1'b1);

`ifdef PE_V3_DIV_EN
      send(ALU, 5'd4, 32'd100, 32'd4, 32'd0, 4'd5);
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_in_ready_low", 32'(in_ready), 32'd0);
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("div_latency", 32'(cyc), 32'd32);
      expect_head("div", 32'd25, 4'd5, 1'b0);
      tick();
      send(ALU, 5'd4, 32'hFFFF_FFFF, 32'd3, 32'd0, 4'd7);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      expect_head("div_big", 32'h5555_5555, 4'd7, 1'b0);
      tick();
      send(ALU, 5'd4, 32'd7, 32'd0, 32'd0, 4'd9);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("div0_latency", 32'(cyc), 32'd32);
      expect_head("div0", 32'hFFFF_FFFF, 4'd9, 1'b1);
      tick();
`else
      op1("div_off", ALU, 5'd4, 32'd100, 32'd4, 32'd0, 4'd5, 32'd0, 1'b1);
      chk("div_off_in_ready", 32'(in_ready), 32'd1);
`endif

      // Backpressure: fill the FIFO, then drain with one overlapped push/pop.
      out_ready = 1'b0;
      send(ALU, 5'd3, 32'd5, 32'd10, 32'd0, 4'd1);
      send(ALU, 5'd3, 32'd6, 32'd10, 32'd0, 4'd2);
      send(ALU, 5'd3, 32'd7, 32'd10, 32'd0, 4'd3);
      chk("bp_ready_3", 32'(in_ready), 32'd1);
      send(ALU, 5'd3, 32'd8, 32'd10, 32'd0, 4'd4);
      chk("bp_ready_full", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      expect_head("bp_head0", 32'd50, 4'd1, 1'b0);
      tick();
      tick();
      expect_head("bp_stable", 32'd50, 4'd1, 1'b0);
      out_ready = 1'b1;
      tick();
      expect_head("bp_pop1", 32'd60, 4'd2, 1'b0);
      chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
      in_opcode = ALU; in_func = 5'd3; in_op1 = 32'd9; in_op2 = 32'd10; in_op3 = '0;
      in_tag = 4'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      expect_head("bp_pop2", 32'd70, 4'd3, 1'b0);
      chk("bp_pushpop_ready", 32'(in_ready), 32'd1);
      tick();
      expect_head("bp_pop3", 32'd80, 4'd4, 1'b0);
      tick();
      expect_head("bp_pop4", 32'd90, 4'd5, 1'b0);
      tick();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Pops while empty must not disturb the count.
      repeat (3) tick();
      chk("empty_pop_valid", 32'(out_valid), 32'd0);
      chk("empty_pop_busy", 32'(busy), 32'd0);
      op1("add_wrap", ALU, 5'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd15, 32'd1, 1'b0);
      chk("add_wrap_popped", 32'(out_valid), 32'd0);

      // Reset with entries waiting in the FIFO.
      out_ready = 1'b0;
      send(ALU, 5'd1, 32'd1, 32'd1, 32'd0, 4'd1);
      send(ALU, 5'd1, 32'd2, 32'd2, 32'd0, 4'd2);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("fifo_rst_valid", 32'(out_valid), 32'd0);
      chk("fifo_rst_ready", 32'(in_ready), 32'd1);
      chk("fifo_rst_result", out_result, 32'd0);
      chk("fifo_rst_busy", 32'(busy), 32'd0);
      out_ready = 1'b1;
      op1("add_after_rst", ALU, 5'd1, 32'd1, 32'd2, 32'd0, 4'd6, 32'd3, 1'b0);

`ifdef PE_V3_DIV_EN
      send(ALU, 5'd4, 32'd100, 32'd4, 32'd0, 4'd8);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("divrst_valid", 32'(out_valid), 32'd0);
      chk("divrst_ready", 32'(in_ready), 32'd1);
      op1("add_after_divrst", ALU, 5'd1, 32'd10, 32'd20, 32'd0, 4'd3, 32'd30, 1'b0);
      repeat (40) tick();
      chk("divrst_no_stray", 32'(out_valid), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
